// File: rtl/counter_cmd_sequencer.sv
// Command sequencer for the 8-bit up/down counter: LOAD/UP/DOWN over valid/ready,
// one pending slot for gapless chaining. Optional auto-repeat under CTRL_REPEAT_EN.
module counter_cmd_sequencer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [1:0]   cmd_op_i,
    input  logic [W-1:0] cmd_arg_i,
    input  logic         hold_i,
`ifdef CTRL_REPEAT_EN
    input  logic         repeat_i,
`endif
    output logic         cnt_load_o,
    output logic [W-1:0] cnt_value_o,
    output logic         cnt_en_o,
    output logic         cnt_dir_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] steps_left_o
);

    // state  | meaning
    // S_IDLE | no command executing, pending slot empty
    // S_LOAD | one-cycle load strobe of the active command
    // S_RUN  | stepping the counter, steps_q > 0 remaining
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b01;

    state_t         state_q, state_d;
    logic [1:0]     act_op_q, act_op_d;
    logic [W-1:0]   act_arg_q, act_arg_d;
    logic [W-1:0]   steps_q, steps_d;
    logic           dir_q, dir_d;
    logic           pend_full_q, pend_full_d;
    logic [1:0]     pend_op_q, pend_op_d;
    logic [W-1:0]   pend_arg_q, pend_arg_d;
    logic           promoted_q, promoted_d;
    logic           done_q, done_d;

    logic           rep;
    logic           accept;
    logic           finish;
    logic           launch;
    logic [1:0]     l_op;
    logic [W-1:0]   l_arg;

`ifdef CTRL_REPEAT_EN
    assign rep = repeat_i;
`else
    assign rep = 1'b0;
`endif

    // The slot stays closed for one extra cycle after its command is promoted.
    assign accept = cmd_valid_i && !pend_full_q && !promoted_q;
    assign finish = (state_q == S_LOAD) ||
                    ((state_q == S_RUN) && !hold_i && (steps_q == W'(1)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            act_op_q    <= '0;
            act_arg_q   <= '0;
            steps_q     <= '0;
            dir_q       <= 1'b0;
            pend_full_q <= 1'b0;
            pend_op_q   <= '0;
            pend_arg_q  <= '0;
            promoted_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_op_q    <= act_op_d;
            act_arg_q   <= act_arg_d;
            steps_q     <= steps_d;
            dir_q       <= dir_d;
            pend_full_q <= pend_full_d;
            pend_op_q   <= pend_op_d;
            pend_arg_q  <= pend_arg_d;
            promoted_q  <= promoted_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        act_op_d    = act_op_q;
        act_arg_d   = act_arg_q;
        steps_d     = steps_q;
        dir_d       = dir_q;
        pend_full_d = pend_full_q;
        pend_op_d   = pend_op_q;
        pend_arg_d  = pend_arg_q;
        promoted_d  = 1'b0;
        done_d      = 1'b0;
        launch      = 1'b0;
        l_op        = cmd_op_i;
        l_arg       = cmd_arg_i;

        if ((state_q == S_RUN) && !hold_i) begin
            steps_d = steps_q - W'(1);
        end

        if (state_q == S_IDLE) begin
            launch = accept;
        end else if (finish) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            if (pend_full_q) begin
                launch      = 1'b1;
                l_op        = pend_op_q;
                l_arg       = pend_arg_q;
                pend_full_d = 1'b0;
                promoted_d  = 1'b1;
            end else if (accept) begin
                launch = 1'b1;
            end else if (rep && act_op_q[1]) begin
                launch = 1'b1;
                l_op   = act_op_q;
                l_arg  = act_arg_q;
            end
        end else if (accept) begin
            pend_full_d = 1'b1;
            pend_op_d   = cmd_op_i;
            pend_arg_d  = cmd_arg_i;
        end

        // A zero-length command chained behind another shares its done pulse.
        if (launch) begin
            act_op_d  = l_op;
            act_arg_d = l_arg;
            if (l_op == OP_LOAD) begin
                state_d = S_LOAD;
            end else if (l_op[1] && (l_arg != '0)) begin
                state_d = S_RUN;
                steps_d = l_arg;
                dir_d   = l_op[0];
            end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_comb begin
        cmd_ready_o  = !pend_full_q && !promoted_q;
        cnt_load_o   = (state_q == S_LOAD);
        cnt_value_o  = (state_q == S_LOAD) ? act_arg_q : '0;
        cnt_en_o     = (state_q == S_RUN) && !hold_i;
        cnt_dir_o    = dir_q;
        busy_o       = (state_q != S_IDLE);
        done_o       = done_q;
        steps_left_o = steps_q;
    end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Bench for counter_cmd_sequencer: directed cases plus randomized traffic checked
// by a per-command scoreboard. Repeat case is built only with CTRL_REPEAT_EN.
module tb_counter_cmd_sequencer;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [1:0] cmd_op_i;
    logic [7:0] cmd_arg_i;
    logic       hold_i;
    logic       rpt;
    logic       cnt_load_o;
    logic [7:0] cnt_value_o;
    logic       cnt_en_o;
    logic       cnt_dir_o;
    logic       busy_o;
    logic       done_o;
    logic [7:0] steps_left_o;

    counter_cmd_sequencer #(.W(8)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_op_i     (cmd_op_i),
        .cmd_arg_i    (cmd_arg_i),
        .hold_i       (hold_i),
`ifdef CTRL_REPEAT_EN
        .repeat_i     (rpt),
`endif
        .cnt_load_o   (cnt_load_o),
        .cnt_value_o  (cnt_value_o),
        .cnt_en_o     (cnt_en_o),
        .cnt_dir_o    (cnt_dir_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .steps_left_o (steps_left_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] arg;
    } cmd_t;

    cmd_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic ld, input logic en, input logic [7:0] sl,
                            input logic dn, input logic bz, input logic rdy);
        check({tag, "_load"},  cnt_load_o,   ld);
        check({tag, "_en"},    cnt_en_o,     en);
        check({tag, "_steps"}, steps_left_o, sl);
        check({tag, "_done"},  done_o,       dn);
        check({tag, "_busy"},  busy_o,       bz);
        check({tag, "_ready"}, cmd_ready_o,  rdy);
    endtask

    // Scoreboard: each accepted command expects, before its done pulse, exactly
    // one load of its value (LOAD), or exactly N enables in its direction (UP/DOWN).
    int   cyc = 0;
    int   cur_loads = 0;
    int   cur_ens = 0;
    int   cur_val = 0;
    int   last_strobe = 0;
    cmd_t e;
    cmd_t ne;

    always @(negedge clk_i) begin
        if (mon_en) begin
            cyc++;
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_loads", cur_loads, (e.op == OP_LOAD) ? 1 : 0);
                    if (e.op == OP_LOAD) check("cmd_load_value", cur_val, e.arg);
                    check("cmd_enables", cur_ens, e.op[1] ? int'(e.arg) : 0);
                    if (e.op == OP_LOAD || (e.op[1] && e.arg != 0))
                        check("done_latency", cyc - last_strobe, 1);
                end
                cur_loads = 0;
                cur_ens = 0;
            end
            if (cnt_load_o || cnt_en_o) check("load_en_exclusive", cnt_load_o & cnt_en_o, 0);
            if (cnt_load_o) begin
                cur_loads++;
                cur_val = cnt_value_o;
                last_strobe = cyc;
            end
            if (cnt_en_o) begin
                if (exp_q.size() == 0) begin
                    check("en_unexpected", 1, 0);
                end else begin
                    e = exp_q[0];
                    check("steps_left", steps_left_o, int'(e.arg) - cur_ens);
                    check("cnt_dir", cnt_dir_o, e.op[0]);
                end
                cur_ens++;
                last_strobe = cyc;
            end
            if (rst_i) begin
                exp_q.delete();
                cur_loads = 0;
                cur_ens = 0;
            end else if (cmd_valid_i && cmd_ready_o) begin
                ne.op = cmd_op_i;
                ne.arg = cmd_arg_i;
                exp_q.push_back(ne);
            end
        end
    end

    initial begin
        int n;
        int k;
        rst_i = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_op_i = OP_NOP;
        cmd_arg_i = 8'h00;
        hold_i = 1'b0;
        rpt = 1'b0;

        // Reset held two cycles
        step();
        step();
        @(negedge clk_i);
        chk_outs("rst", 0, 0, 8'd0, 0, 0, 1);
        check("rst_value", cnt_value_o, 0);
        check("rst_dir", cnt_dir_o, 0);
        step();
        rst_i = 1'b0;

        // LOAD 0x5A
        step();
        cmd_valid_i = 1'b1; cmd_op_i = OP_LOAD; cmd_arg_i = 8'h5A;
        @(negedge clk_i);
        check("load_T_ready", cmd_ready_o, 1);
        step();
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        chk_outs("load_T1", 1, 0, 8'd0, 0, 1, 1);
        check("load_T1_value", cnt_value_o, 8'h5A);
        step();
        @(negedge clk_i);
        chk_outs("load_T2", 0, 0, 8'd0, 1, 0, 1);
        check("load_T2_value", cnt_value_o, 0);

        // UP 3 with hold on the second step cycle
        step();
        cmd_valid_i = 1'b1; cmd_op_i = OP_UP; cmd_arg_i = 8'd3;
        step();
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        chk_outs("hold_T1", 0, 1, 8'd3, 0, 1, 1);
        check("hold_T1_dir", cnt_dir_o, 0);
        step();
        hold_i = 1'b1;
        @(negedge clk_i);
        chk_outs("hold_T2", 0, 0, 8'd2, 0, 1, 1);
        step();
        hold_i = 1'b0;
        @(negedge clk_i);
        chk_outs("hold_T3", 0, 1, 8'd2, 0, 1, 1);
        step();
        @(negedge clk_i);
        chk_outs("hold_T4", 0, 1, 8'd1, 0, 1, 1);
        step();
        @(negedge clk_i);
        chk_outs("hold_T5", 0, 0, 8'd0, 1, 0, 1);

        // DOWN 2 then UP 1 queued behind it
        step();
        cmd_valid_i = 1'b1; cmd_op_i = OP_DOWN; cmd_arg_i = 8'd2;
        step();
        cmd_op_i = OP_UP; cmd_arg_i = 8'd1;
        @(negedge clk_i);
        chk_outs("chain_T1", 0, 1, 8'd2, 0, 1, 1);
        check("chain_T1_dir", cnt_dir_o, 1);
        step();
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        chk_outs("chain_T2", 0, 1, 8'd1, 0, 1, 0);
        check("chain_T2_dir", cnt_dir_o, 1);
        step();
        @(negedge clk_i);
        chk_outs("chain_T3", 0, 1, 8'd1, 1, 1, 0);
        check("chain_T3_dir", cnt_dir_o, 0);
        step();
        @(negedge clk_i);
        chk_outs("chain_T4", 0, 0, 8'd0, 1, 0, 1);

        // UP 0 completes without strobes
        step();
        cmd_valid_i = 1'b1; cmd_op_i = OP_UP; cmd_arg_i = 8'd0;
        @(negedge clk_i);
        check("up0_T_busy", busy_o, 0);
        step();
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        chk_outs("up0_T1", 0, 0, 8'd0, 1, 0, 1);
        step();
        @(negedge clk_i);
        chk_outs("up0_T2", 0, 0, 8'd0, 0, 0, 1);

        // Reset in the middle of RUN with a command pending
        step();
        cmd_valid_i = 1'b1; cmd_op_i = OP_UP; cmd_arg_i = 8'd6;
        step();
        cmd_arg_i = 8'd2;
        @(negedge clk_i);
        check("mrst_T1_steps", steps_left_o, 6);
        step();
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        chk_outs("mrst_T2", 0, 1, 8'd5, 0, 1, 0);
        step();
        rst_i = 1'b1;
        @(negedge clk_i);
        check("mrst_T3_steps", steps_left_o, 4);
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk_outs("mrst_T4", 0, 0, 8'd0, 0, 0, 1);
        step();
        @(negedge clk_i);
        chk_outs("mrst_T5", 0, 0, 8'd0, 0, 0, 1);

        // Maximum step count
        step();
        cmd_valid_i = 1'b1; cmd_op_i = OP_UP; cmd_arg_i = 8'd255;
        step();
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        check("maxn_T1_steps", steps_left_o, 255);
        n = 1;
        while (!done_o && n < 400) begin
            step();
            @(negedge clk_i);
            n++;
        end
        check("maxn_done_cycle", n, 256);

        // Randomized traffic with random hold
        for (int i = 0; i < 1500; i++) begin
            step();
            hold_i = ($urandom_range(0, 3) == 0);
            k = $urandom_range(0, 9);
            cmd_valid_i = ($urandom_range(0, 2) != 0);
            if (k < 3) begin
                cmd_op_i = OP_LOAD;
                cmd_arg_i = 8'($urandom_range(0, 255));
            end else if (k < 9) begin
                cmd_op_i = ($urandom_range(0, 1) == 0) ? OP_UP : OP_DOWN;
                cmd_arg_i = (k == 8) ? 8'($urandom_range(1, 30)) : 8'($urandom_range(1, 5));
            end else if (!busy_o) begin
                cmd_op_i = ($urandom_range(0, 1) == 0) ? OP_NOP : OP_DOWN;
                cmd_arg_i = 8'd0;
            end else begin
                cmd_valid_i = 1'b0;
            end
        end
        step();
        cmd_valid_i = 1'b0;
        hold_i = 1'b0;
        n = 0;
        @(negedge clk_i);
        while ((busy_o || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        check("drain_timeout", (n < 3000) ? 1 : 0, 1);
        check("drain_queue_empty", exp_q.size(), 0);

`ifdef CTRL_REPEAT_EN
        // UP 2 repeated: enable continuous, done every second cycle
        mon_en = 1'b0;
        step();
        cmd_valid_i = 1'b1; cmd_op_i = OP_UP; cmd_arg_i = 8'd2; rpt = 1'b1;
        step();
        cmd_valid_i = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk_i);
            check("rpt_en", cnt_en_o, 1);
            check("rpt_done", done_o, (i == 3 || i == 5) ? 1 : 0);
            check("rpt_busy", busy_o, 1);
            step();
        end
        rpt = 1'b0;
        n = 0;
        @(negedge clk_i);
        while (busy_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("rpt_stop", busy_o, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
